// File: rtl/pll_seq_pkg.sv
// Shared types and constants for the PLL reconfiguration sequencer.
// Holds the sequencer states, pll_cfg register map and default fractional-K words.
package pll_seq_pkg;

    typedef enum logic [2:0] {
        IDLE,
        WR_MODE,
        GAP,
        WR_K,
        WR_START,
        WAIT_UNLOCK,
        WAIT_LOCK
    } seq_state_e;

    localparam logic [5:0] REG_MODE  = 6'd0;
    localparam logic [5:0] REG_START = 6'd2;
    localparam logic [5:0] REG_KFRAC = 6'd7;

    // Profile 0 is native speed, profile 1 is the 60 Hz-adjusted setting.
    localparam logic [31:0] K_NATIVE = 32'd3639383488;
    localparam logic [31:0] K_60HZ   = 32'd3262113561;
    localparam logic [3:0][31:0] K_TABLE_DEFAULT = {32'd0, 32'd0, K_60HZ, K_NATIVE};

    function automatic logic is_write_state(input seq_state_e s);
        return (s == WR_MODE) || (s == WR_K) || (s == WR_START);
    endfunction

endpackage

// File: rtl/pll_sel_filter.sv
// Two-flop synchronizer followed by a stability filter: stable_o asserts once
// STABLE_CYCLES consecutive identical synchronized samples have been seen.
module pll_sel_filter
    import pll_seq_pkg::*;
#(
    parameter int W             = 1,
    parameter int STABLE_CYCLES = 2
) (
    input  logic         clk,
    input  logic         reset,
    input  logic [W-1:0] din,
    output logic [W-1:0] dout,
    output logic         stable
);

    localparam int CW = (STABLE_CYCLES < 1) ? 1 : $clog2(STABLE_CYCLES + 1);
    localparam logic [CW-1:0] STABLE_C = CW'(STABLE_CYCLES);

    logic [W-1:0]  s1_q;
    logic [W-1:0]  s2_q;
    logic [W-1:0]  hold_q;
    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    genvar gi;
    generate
        for (gi = 0; gi < W; gi++) begin : g_sync
            always_ff @(posedge clk) begin
                if (reset) begin
                    s1_q[gi] <= 1'b0;
                    s2_q[gi] <= 1'b0;
                end else begin
                    s1_q[gi] <= din[gi];
                    s2_q[gi] <= s1_q[gi];
                end
            end
        end
    endgenerate

    // A new synchronized value counts as its own first sample.
    always_comb begin
        cnt_d = cnt_q;
        if (s2_q != hold_q) begin
            cnt_d = CW'(1);
        end else if (cnt_q < STABLE_C) begin
            cnt_d = cnt_q + CW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            hold_q <= '0;
            cnt_q  <= '0;
        end else begin
            hold_q <= s2_q;
            cnt_q  <= cnt_d;
        end
    end

    assign dout   = hold_q;
    assign stable = (cnt_q >= STABLE_C);

endmodule

// File: rtl/pll_reconfig_seq.sv
// Drives the pll_cfg Avalon-MM port through mode, K and start writes whenever the
// filtered profile select settles on a new profile, then waits for the PLL to relock.
module pll_reconfig_seq
    import pll_seq_pkg::*;
#(
    parameter int NUM_PROFILES               = 2,
    parameter int PROF_W                     = 1,
    parameter logic [3:0][31:0] K_TABLE      = K_TABLE_DEFAULT,
    parameter int STABLE_CYCLES              = 2,
    parameter int GAP_CYCLES                 = 3,
    parameter int LOCK_TIMEOUT               = 1000000
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [PROF_W-1:0] profile_sel,
    input  logic              locked,
    input  logic              mgmt_waitrequest,
    output logic              mgmt_write,
    output logic [5:0]        mgmt_address,
    output logic [31:0]       mgmt_writedata,
    output logic              busy,
    output logic              done,
    output logic              lock_err,
    output logic [PROF_W-1:0] applied_profile
);

    localparam int GW = (GAP_CYCLES < 2) ? 1 : $clog2(GAP_CYCLES);
    localparam logic [GW-1:0] GAP_LAST = GW'(GAP_CYCLES - 1);
    localparam int TW = (LOCK_TIMEOUT < 2) ? 1 : $clog2(LOCK_TIMEOUT);
    localparam logic [TW-1:0] TMO_LAST = TW'(LOCK_TIMEOUT - 1);
    localparam logic [PROF_W:0] NUM_P = (PROF_W + 1)'(NUM_PROFILES);

    logic [PROF_W-1:0] sel_filt;
    logic              sel_stable;
    logic              sel_valid;
    logic [1:0]        lock_sync_q;
    logic              lock_s;

    seq_state_e        state_q, state_d;
    seq_state_e        gap_next_q, gap_next_d;
    logic [GW-1:0]     gap_q, gap_d;
    logic [TW-1:0]     tmo_q, tmo_d;
    logic [PROF_W-1:0] target_q, target_d;
    logic [PROF_W-1:0] applied_q, applied_d;
    logic              done_q, done_d;
    logic              lock_err_q, lock_err_d;
    logic              wr_accept;
    logic [1:0]        k_idx;

    pll_sel_filter #(
        .W             (PROF_W),
        .STABLE_CYCLES (STABLE_CYCLES)
    ) u_sel_filter (
        .clk    (clk),
        .reset  (reset),
        .din    (profile_sel),
        .dout   (sel_filt),
        .stable (sel_stable)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            lock_sync_q <= 2'b00;
        end else begin
            lock_sync_q <= {lock_sync_q[0], locked};
        end
    end

    assign lock_s    = lock_sync_q[1];
    assign sel_valid = ({1'b0, sel_filt} < NUM_P);
    assign wr_accept = !mgmt_waitrequest;
    assign k_idx     = 2'(target_q);

    always_comb begin
        state_d    = state_q;
        gap_next_d = gap_next_q;
        gap_d      = gap_q;
        tmo_d      = '0;
        target_d   = target_q;
        applied_d  = applied_q;
        done_d     = 1'b0;
        lock_err_d = lock_err_q;
        case (state_q)
            IDLE: begin
                if (sel_stable && sel_valid && (sel_filt != applied_q)) begin
                    target_d   = sel_filt;
                    lock_err_d = 1'b0;
                    state_d    = WR_MODE;
                end
            end
            WR_MODE: begin
                if (wr_accept) begin
                    gap_d      = '0;
                    gap_next_d = WR_K;
                    state_d    = GAP;
                end
            end
            GAP: begin
                if (gap_q == GAP_LAST) begin
                    state_d = gap_next_q;
                end else begin
                    gap_d = gap_q + GW'(1);
                end
            end
            WR_K: begin
                if (wr_accept) begin
                    gap_d      = '0;
                    gap_next_d = WR_START;
                    state_d    = GAP;
                end
            end
            WR_START: begin
                if (wr_accept) begin
                    state_d = WAIT_UNLOCK;
                end
            end
            // Some PLLs relock too fast to ever show a low locked; a timeout here is benign.
            WAIT_UNLOCK: begin
                if (!lock_s || (tmo_q == TMO_LAST)) begin
                    state_d = WAIT_LOCK;
                end else begin
                    tmo_d = tmo_q + TW'(1);
                end
            end
            WAIT_LOCK: begin
                if (lock_s) begin
                    applied_d = target_q;
                    done_d    = 1'b1;
                    state_d   = IDLE;
                end else if (tmo_q == TMO_LAST) begin
                    applied_d  = target_q;
                    lock_err_d = 1'b1;
                    state_d    = IDLE;
                end else begin
                    tmo_d = tmo_q + TW'(1);
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IDLE;
            gap_next_q <= WR_K;
            gap_q      <= '0;
            tmo_q      <= '0;
            target_q   <= '0;
            applied_q  <= '0;
            done_q     <= 1'b0;
            lock_err_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            gap_next_q <= gap_next_d;
            gap_q      <= gap_d;
            tmo_q      <= tmo_d;
            target_q   <= target_d;
            applied_q  <= applied_d;
            done_q     <= done_d;
            lock_err_q <= lock_err_d;
        end
    end

    // Bus outputs decode from registered state only, so they hold steady under waitrequest.
    always_comb begin
        mgmt_address   = REG_MODE;
        mgmt_writedata = '0;
        case (state_q)
            WR_K: begin
                mgmt_address   = REG_KFRAC;
                mgmt_writedata = K_TABLE[k_idx];
            end
            WR_START: begin
                mgmt_address = REG_START;
            end
            default: begin
                mgmt_address   = REG_MODE;
                mgmt_writedata = '0;
            end
        endcase
    end

    assign mgmt_write      = is_write_state(state_q);
    assign busy            = (state_q != IDLE);
    assign done            = done_q;
    assign lock_err        = lock_err_q;
    assign applied_profile = applied_q;

endmodule

// File: tb/tb_pll_reconfig_seq.sv
// Scoreboard bench for pll_reconfig_seq: expected writes and sequence outcomes are
// queued by the stimulus and checked by an independent bus monitor.
module tb_pll_reconfig_seq;

    localparam logic [31:0] K0 = 32'd3639383488;
    localparam logic [31:0] K1 = 32'd3262113561;
    localparam int GAP_N = 3;

    typedef struct {
        logic [5:0]  addr;
        logic [31:0] data;
        int          len;
    } wr_t;

    typedef struct {
        logic applied;
        logic dn;
        logic err;
    } end_t;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [0:0]  profile_sel = 1'b0;
    logic        locked = 1'b1;
    logic        mgmt_waitrequest = 1'b0;
    logic        mgmt_write;
    logic [5:0]  mgmt_address;
    logic [31:0] mgmt_writedata;
    logic        busy;
    logic        done;
    logic        lock_err;
    logic [0:0]  applied_profile;

    int   total = 0;
    int   bad = 0;
    int   acc_cnt = 0;
    int   done_cnt = 0;
    bit   stall_k = 0;
    int   stall_len = 20;
    wr_t  exp_wr[$];
    end_t exp_end[$];

    pll_reconfig_seq #(
        .NUM_PROFILES  (2),
        .PROF_W        (1),
        .STABLE_CYCLES (2),
        .GAP_CYCLES    (GAP_N),
        .LOCK_TIMEOUT  (100)
    ) dut (
        .clk              (clk),
        .reset            (reset),
        .profile_sel      (profile_sel),
        .locked           (locked),
        .mgmt_waitrequest (mgmt_waitrequest),
        .mgmt_write       (mgmt_write),
        .mgmt_address     (mgmt_address),
        .mgmt_writedata   (mgmt_writedata),
        .busy             (busy),
        .done             (done),
        .lock_err         (lock_err),
        .applied_profile  (applied_profile)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end else begin
            $display("ok   %s: %0d", name, act);
        end
    endtask

    task automatic fail(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        bad++;
        $display("FAIL %s: got %0d expected %0d", name, act, exp);
    endtask

    task automatic push_seq(input logic [31:0] k, input int klen, input logic app,
                            input logic dn, input logic err);
        exp_wr.push_back('{6'd0, 32'd0, 1});
        exp_wr.push_back('{6'd7, k, klen});
        exp_wr.push_back('{6'd2, 32'd0, 1});
        exp_end.push_back('{app, dn, err});
    endtask

    task automatic wait_accept(input logic [5:0] a, input int budget, output bit ok);
        ok = 0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (mgmt_write && !mgmt_waitrequest && mgmt_address == a) begin
                ok = 1;
                break;
            end
        end
        if (!ok) fail($sformatf("wait_accept_addr%0d_timeout", a), 0, 1);
    endtask

    task automatic wait_idle(input int budget);
        bit ok;
        ok = 0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (!busy) begin
                ok = 1;
                break;
            end
        end
        if (!ok) fail("wait_idle_timeout", 1, 0);
    endtask

    // mode 0: drop 10 cycles after start write, relock 50 later; 1: never drop; 2: drop forever
    task automatic run_lock(input int mode);
        bit ok;
        wait_accept(6'd2, 400, ok);
        if (ok && mode != 1) begin
            repeat (10) @(negedge clk);
            locked = 1'b0;
            if (mode == 0) begin
                repeat (50) @(negedge clk);
                locked = 1'b1;
            end
        end
    endtask

    // waitrequest model: optionally stalls the next K write
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (stall_k && mgmt_write && mgmt_address == 6'd7) begin
                stall_k = 0;
                mgmt_waitrequest = 1'b1;
                for (int i = 0; i < stall_len && !reset; i++) @(posedge clk);
                #1 mgmt_waitrequest = 1'b0;
            end
        end
    end

    // Bus / outcome monitor
    initial begin
        int   cur_len;
        int   idle_cnt;
        bit   busy_prev;
        bit   prev_hold;
        logic [5:0]  hold_addr;
        logic [31:0] hold_data;
        wr_t  w;
        end_t e;
        cur_len = 0;
        idle_cnt = 1000;
        busy_prev = 0;
        prev_hold = 0;
        hold_addr = '0;
        hold_data = '0;
        forever begin
            @(negedge clk);
            if (reset) begin
                cur_len = 0;
                prev_hold = 0;
                busy_prev = 0;
                idle_cnt = 1000;
            end else begin
                if (mgmt_write) begin
                    if (cur_len == 0) check("gap_before_write", 64'(idle_cnt >= GAP_N), 1);
                    if (prev_hold) begin
                        if (mgmt_address !== hold_addr) fail("hold_addr", mgmt_address, hold_addr);
                        if (mgmt_writedata !== hold_data) fail("hold_data", mgmt_writedata, hold_data);
                    end
                    cur_len++;
                    if (!mgmt_waitrequest) begin
                        acc_cnt++;
                        if (exp_wr.size() == 0) begin
                            fail("unexpected_write_addr", mgmt_address, 0);
                        end else begin
                            w = exp_wr.pop_front();
                            check("wr_addr", mgmt_address, w.addr);
                            check("wr_data", mgmt_writedata, w.data);
                            check("wr_strobe_len", cur_len, w.len);
                        end
                        cur_len = 0;
                        idle_cnt = 0;
                        prev_hold = 0;
                    end else begin
                        prev_hold = 1;
                        hold_addr = mgmt_address;
                        hold_data = mgmt_writedata;
                    end
                end else begin
                    if (cur_len != 0) fail("write_dropped_unaccepted", cur_len, 0);
                    cur_len = 0;
                    prev_hold = 0;
                    if (idle_cnt < 1000) idle_cnt++;
                end
                if (done) done_cnt++;
                if (busy_prev && !busy) begin
                    if (exp_end.size() == 0) begin
                        fail("unexpected_seq_end", 1, 0);
                    end else begin
                        e = exp_end.pop_front();
                        check("end_applied", applied_profile, e.applied);
                        check("end_done", done, e.dn);
                        check("end_lock_err", lock_err, e.err);
                    end
                end
                busy_prev = busy;
            end
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: got 1 expected 0");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int  acc_save;
        bit  ok;
        // reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_write", mgmt_write, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_lock_err", lock_err, 0);
        check("rst_applied", applied_profile, 0);
        check("rst_address", mgmt_address, 0);
        @(posedge clk);
        #1 reset = 1'b0;

        // profile 0 held: nothing happens
        repeat (100) @(negedge clk);
        check("idle_busy", busy, 0);
        check("idle_applied", applied_profile, 0);
        check("idle_no_writes", acc_cnt, 0);

        // 0 -> 1, plain handshake
        push_seq(K1, 1, 1'b1, 1'b1, 1'b0);
        profile_sel = 1'b1;
        run_lock(0);
        wait_idle(500);

        // 1 -> 0 with K write stalled 20 cycles
        stall_len = 20;
        stall_k = 1;
        push_seq(K0, 21, 1'b0, 1'b1, 1'b0);
        profile_sel = 1'b0;
        run_lock(0);
        wait_idle(500);

        // toggling select never starts a sequence
        acc_save = acc_cnt;
        repeat (30) begin
            @(negedge clk);
            profile_sel = ~profile_sel;
        end
        @(negedge clk);
        profile_sel = 1'b0;
        repeat (6) @(negedge clk);
        check("toggle_no_writes", acc_cnt, acc_save);
        check("toggle_busy", busy, 0);

        // held 1 with locked never dropping: unlock timeout is benign
        push_seq(K1, 1, 1'b1, 1'b1, 1'b0);
        profile_sel = 1'b1;
        run_lock(1);
        wait_idle(500);

        // 1 -> 0 with the PLL never relocking: lock_err and applied still updated
        push_seq(K0, 1, 1'b0, 1'b0, 1'b1);
        profile_sel = 1'b0;
        run_lock(2);
        wait_idle(1000);
        repeat (5) @(negedge clk);
        check("lock_err_sticky", lock_err, 1);
        check("lock_err_busy", busy, 0);
        locked = 1'b1;
        repeat (5) @(negedge clk);

        // next sequence clears lock_err at start
        push_seq(K1, 1, 1'b1, 1'b1, 1'b0);
        profile_sel = 1'b1;
        ok = 0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (busy) begin
                ok = 1;
                break;
            end
        end
        check("start_seen", ok, 1);
        check("lock_err_cleared", lock_err, 0);
        run_lock(0);
        wait_idle(500);

        // reset while the K write is stalled
        exp_wr.push_back('{6'd0, 32'd0, 1});
        stall_len = 1000;
        stall_k = 1;
        profile_sel = 1'b0;
        ok = 0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (mgmt_write && mgmt_address == 6'd7) begin
                ok = 1;
                break;
            end
        end
        check("k_stall_seen", ok, 1);
        repeat (5) @(negedge clk);
        check("k_stall_held", mgmt_write, 1);
        @(posedge clk);
        #1 reset = 1'b1;
        profile_sel = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check("rst_mid_write", mgmt_write, 0);
        check("rst_mid_applied", applied_profile, 0);
        check("rst_mid_busy", busy, 0);
        repeat (3) @(posedge clk);
        push_seq(K1, 1, 1'b1, 1'b1, 1'b0);
        #1 reset = 1'b0;
        run_lock(0);
        wait_idle(500);
        repeat (10) @(negedge clk);

        check("done_pulses", done_cnt, 5);
        check("final_applied", applied_profile, 1);
        check("wr_queue_empty", exp_wr.size(), 0);
        check("end_queue_empty", exp_end.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
